// File: rtl/summer_bank.sv
// -----------------------------------------------------------------------------
// summer_bank
//
// Multi-channel accumulator bank. It holds CHANNELS = 2**CHAN_BITS independent
// WIDTH-bit accumulators and accepts one request per cycle over a valid/ready
// handshake. Each accepted request produces exactly one registered response.
//
// Operations (in_op):
//   0 SUM  : out_sum = a + b, out_carry = carry, accumulator untouched
//   1 ACC  : acc[ch] += a, out_sum = new acc, out_carry = carry,
//            and a carry sets the sticky ovf_mask[ch]
//   2 LOAD : acc[ch] = a, ovf_mask[ch] cleared, out_sum = a, out_carry = 0
//   3 READ : out_sum = acc[ch], out_carry = 0, no state change
//
// Ports:
//   clock, reset         single clock, synchronous active-high reset
//   in_valid/in_ready    request handshake (in_ready = !out_valid || out_ready)
//   in_chan, in_op       target channel and operation
//   in_a, in_b           operands (in_b is used by SUM only)
//   out_valid/out_ready  response handshake (one-entry output register)
//   out_chan, out_sum,   channel, result and carry of the held response
//   out_carry
//   ovf_mask             sticky per-channel overflow flags
//   peek_chan/peek_value combinational debug view of the committed acc state
//
// Build option:
//   SUMMER_BANK_SATURATE_EN  when defined, SUM and ACC clamp to 2**WIDTH-1 on
//                            carry (the carry and overflow flag still report 1).
//                            When undefined, arithmetic wraps modulo 2**WIDTH.
// -----------------------------------------------------------------------------
module summer_bank #(
  parameter int WIDTH     = 8,
  parameter int CHAN_BITS = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHAN_BITS-1:0]      in_chan,
  input  logic [1:0]                in_op,
  input  logic [WIDTH-1:0]          in_a,
  input  logic [WIDTH-1:0]          in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHAN_BITS-1:0]      out_chan,
  output logic [WIDTH-1:0]          out_sum,
  output logic                      out_carry,
  output logic [(2**CHAN_BITS)-1:0] ovf_mask,
  input  logic [CHAN_BITS-1:0]      peek_chan,
  output logic [WIDTH-1:0]          peek_value
);

  localparam int CHANNELS = 2**CHAN_BITS;

  localparam logic [1:0] OP_SUM  = 2'd0;
  localparam logic [1:0] OP_ACC  = 2'd1;
  localparam logic [1:0] OP_LOAD = 2'd2;
  localparam logic [1:0] OP_READ = 2'd3;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0][WIDTH-1:0] acc_reg;
  logic [CHANNELS-1:0][WIDTH-1:0] acc_next;
  logic [CHANNELS-1:0]            ovf_reg;
  logic [CHANNELS-1:0]            ovf_next;

  logic                 out_valid_reg;
  logic                 out_valid_next;
  logic [CHAN_BITS-1:0] out_chan_reg;
  logic [CHAN_BITS-1:0] out_chan_next;
  logic [WIDTH-1:0]     out_sum_reg;
  logic [WIDTH-1:0]     out_sum_next;
  logic                 out_carry_reg;
  logic                 out_carry_next;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic accept;

  // A new request may enter whenever the single output slot is empty or is
  // being drained in this very cycle.
  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Shared adder
  // ---------------------------------------------------------------------------
  // One WIDTH+1 adder serves both SUM (a+b) and ACC (acc[ch]+a); the operand
  // muxes pick the pair based on the opcode.
  logic [WIDTH-1:0] sel_acc;
  logic [WIDTH-1:0] add_lhs;
  logic [WIDTH-1:0] add_rhs;
  logic [WIDTH:0]   add_wide;
  logic             add_carry;
  logic [WIDTH-1:0] add_result;

  assign sel_acc = acc_reg[in_chan];

  always_comb begin
    add_lhs = sel_acc;
    add_rhs = in_a;
    if (in_op == OP_SUM) begin
      add_lhs = in_a;
      add_rhs = in_b;
    end
  end

  assign add_wide  = {1'b0, add_lhs} + {1'b0, add_rhs};
  assign add_carry = add_wide[WIDTH];

`ifdef SUMMER_BANK_SATURATE_EN
  // Clamp to all-ones when the addition overflows; the carry is still reported.
  assign add_result = add_carry ? {WIDTH{1'b1}} : add_wide[WIDTH-1:0];
`else
  // Plain modulo-2**WIDTH wrap.
  assign add_result = add_wide[WIDTH-1:0];
`endif

  // ---------------------------------------------------------------------------
  // Per-channel accumulator and sticky overflow update
  // ---------------------------------------------------------------------------
  // Each channel only reacts to an accepted request addressed to it. The acc
  // is written at the accept edge, so a back-to-back ACC on the same channel
  // already reads the updated value through sel_acc.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic hit;
      logic hit_acc;
      logic hit_load;

      assign hit      = accept && (in_chan == CHAN_BITS'(gi));
      assign hit_acc  = hit && (in_op == OP_ACC);
      assign hit_load = hit && (in_op == OP_LOAD);

      assign acc_next[gi] = hit_acc  ? add_result :
                            hit_load ? in_a       :
                                       acc_reg[gi];

      assign ovf_next[gi] = hit_load               ? 1'b0 :
                            (hit_acc && add_carry) ? 1'b1 :
                                                     ovf_reg[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Response register next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid_next = out_valid_reg;
    out_chan_next  = out_chan_reg;
    out_sum_next   = out_sum_reg;
    out_carry_next = out_carry_reg;

    if (accept) begin
      // A new response replaces the held one (the old one is being consumed
      // in the same cycle, otherwise accept could not be high).
      out_valid_next = 1'b1;
      out_chan_next  = in_chan;
      unique case (in_op)
        OP_SUM, OP_ACC: begin
          out_sum_next   = add_result;
          out_carry_next = add_carry;
        end
        OP_LOAD: begin
          out_sum_next   = in_a;
          out_carry_next = 1'b0;
        end
        default: begin
          out_sum_next   = sel_acc;
          out_carry_next = 1'b0;
        end
      endcase
    end else if (out_ready) begin
      // Drained with nothing new: drop valid, keep the payload as it was.
      out_valid_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_reg       <= '0;
      ovf_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_chan_reg  <= '0;
      out_sum_reg   <= '0;
      out_carry_reg <= 1'b0;
    end else begin
      acc_reg       <= acc_next;
      ovf_reg       <= ovf_next;
      out_valid_reg <= out_valid_next;
      out_chan_reg  <= out_chan_next;
      out_sum_reg   <= out_sum_next;
      out_carry_reg <= out_carry_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid  = out_valid_reg;
  assign out_chan   = out_chan_reg;
  assign out_sum    = out_sum_reg;
  assign out_carry  = out_carry_reg;
  assign ovf_mask   = ovf_reg;
  assign peek_value = acc_reg[peek_chan];

endmodule

// File: doc/summer_bank.md
Name: summer_bank

Overview:
- Parametrised, multi-channel successor to the two-method adder submodule.
- Holds CHANNELS independent W-bit accumulators, selected by a channel index.
- Accepts one request per cycle over a valid/ready handshake; returns one registered response per request.
- Sits between a caller module and downstream logic. Typical callers are sequencers that need per-lane running sums and carry reporting.

Parameters:
- WIDTH, 8: operand, accumulator and result width in bits.
- CHAN_BITS, 2: channel index width; CHANNELS = 2**CHAN_BITS (default 4).

Ports:
- clock  input  1  single clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_chan  input  CHAN_BITS  target channel.
- in_op  input  2  0=SUM, 1=ACC, 2=LOAD, 3=READ.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B (used by SUM only).
- out_valid  output  1  response valid.
- out_ready  input  1  response consumed when out_valid && out_ready.
- out_chan  output  CHAN_BITS  channel of the response.
- out_sum  output  WIDTH  result.
- out_carry  output  1  carry out of the addition for this response.
- ovf_mask  output  CHANNELS  sticky per-channel overflow flags.
- peek_chan  input  CHAN_BITS  debug read select.
- peek_value  output  WIDTH  combinational acc[peek_chan].

Behaviour:
- Reset (synchronous, reset=1 at an edge):
  - all acc[i]=0, ovf_mask=0.
  - out_valid=0, out_chan=0, out_sum=0, out_carry=0.
  - reset overrides any accept or consume in the same cycle.
- in_ready = !out_valid || out_ready (combinational; one-entry output register, no extra buffering).
- Latency: a request accepted at edge N has its response visible after edge N, so out_valid=1 in cycle N+1.
- Ops, all computed at WIDTH+1 bits, with the low WIDTH bits as the result and bit WIDTH as the carry:
  - SUM: out_sum=a+b; out_carry=carry; acc unchanged.
  - ACC: t=acc[ch]+a; acc[ch]<=t[W-1:0]; out_sum=t[W-1:0]; out_carry=t[W]; if t[W] then ovf_mask[ch]<=1.
  - LOAD: acc[ch]<=a; ovf_mask[ch]<=0; out_sum=a; out_carry=0.
  - READ: out_sum=acc[ch]; out_carry=0; no state change.
- Back-to-back ACC to the same channel: the second request sees the value written by the first (no bypass hazard; acc is written at the accept edge).
- Response hold: while out_valid && !out_ready, all out_* outputs are stable and in_ready=0. No accepts are made and no acc changes occur.
- Simultaneous consume and accept in one cycle: the new response replaces the old one; out_valid stays 1.
- Consume with no accept: out_valid<=0, and out_sum/out_chan/out_carry hold their last values.
- Wrap-around: without the optional feature, ACC wraps modulo 2**WIDTH. Example: 0xFF+0x02 gives 0x01 with carry=1.
- in_b is ignored for ACC, LOAD and READ; in_a is ignored for READ.
- peek_value reflects the committed acc state, so an accepted ACC is visible on peek from the next cycle.
- Reset asserted while a response is pending: the response is dropped and out_valid=0 on the next cycle.

Optional Feature:
- Macro: SUMMER_BANK_SATURATE_EN.
- Defined: SUM and ACC saturate.
  - If the carry is 1, the result is 2**WIDTH-1, acc stores the saturated value, and out_carry and the ovf flag still report 1.
- Undefined: wrap-around arithmetic as described in Behaviour; no saturation logic is instantiated.

Test Plan:
- Reset, then SUM ch0 a=1 b=2 with out_ready=1 -> cycle+1 out_valid=1, out_sum=3, out_carry=0, out_chan=0; peek_value(ch0)=0.
- LOAD ch2 a=0xF0, then ACC ch2 a=0x20 on consecutive cycles -> responses 0xF0/carry0, then 0x10/carry1; ovf_mask=4'b0100. With SUMMER_BANK_SATURATE_EN the second response is 0xFF/carry1.
- Backpressure: out_ready=0, issue SUM a=5 b=6, hold in_valid with the next SUM a=7 b=8 -> out_sum stays 11 and in_ready=0 for 3 cycles. Raise out_ready -> the next response is 15 with no lost or duplicate response.
- Streaming: out_ready=1, ACC ch1 a=1 for 10 consecutive cycles -> in_ready=1 throughout; out_sum sequence 1..10; peek_value(ch1)=10.
- Channel isolation: ACC ch0 a=3, ACC ch3 a=9, READ ch0, READ ch3 -> 3, 9, 3, 9; ch1 and ch2 stay 0.
- Mid-operation reset: response pending with out_ready=0, assert reset for 1 cycle -> out_valid=0, ovf_mask=0, and all peek_value=0 from the next cycle.
